ifetch_ctl: RTL and testbench

Instruction fetch sequencer for the P-D3 control unit. On request it reads one word at IC over the memory bus handshake and strobes it into the instruction register (IR). It then increments IC and screens privileged opcodes in user mode, clearing IR[0:1] through the IR invalidate input and raising an illegal-instruction interrupt. It also detects a memory no-answer timeout.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/ifetch_ctl_req_timer.sv | 43 ++++
 rtl/ifetch_ctl.sv | 121 ++++++++++++
 tb/tb_ifetch_ctl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the P-D3 control unit: fetch FSM states, word width
// and the default bus no-answer limit.
package cpu_pkg;

   localparam int unsigned WORD_W      = 16;
   localparam int unsigned TIMEOUT_DEF = 16;
   localparam int unsigned TMR_W       = 8;

   typedef enum logic [1:0] {
      IFS_IDLE  = 2'd0,
      IFS_REQ   = 2'd1,
      IFS_CHECK = 2'd2,
      IFS_ALARM = 2'd3
   } ifs_state_e;

   // Instruction counter advance; wraps 16'hFFFF -> 16'h0000.
   function automatic logic [WORD_W-1:0] ic_next(input logic [WORD_W-1:0] ic_v);
      return ic_v + 16'd1;
   endfunction

endpackage

// File: rtl/ifetch_ctl_req_timer.sv
// Bus request watchdog: 8-bit clear/enable counter that flags the last
// allowed request cycle (count == LIMIT-1).
module req_timer
   import cpu_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_DEF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TMR_W-1:0] LAST = TMR_W'(LIMIT - 1);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Clear wins over count enable.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 8'd0;
      end else if (en_i) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/ifetch_ctl.sv
// Instruction fetch sequencer: reads one word at IC into the IR, advances IC,
// screens privileged opcodes in user mode and watches for memory no-answer.
module ifetch_ctl
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic            ic_load,
   input  logic [0:WORD_W-1] ic_d,
   input  logic            mem_ok,
   input  logic            user,
   input  logic            ir_priv,
   output logic            mem_req,
   output logic [0:WORD_W-1] mem_addr,
   output logic            ir_c,
   output logic            ir_invalidate,
   output logic [0:WORD_W-1] ic,
   output logic            busy,
   output logic            fetched,
   output logic            illegal_irq,
   output logic            no_answer_irq
);

   ifs_state_e          state_q;
   ifs_state_e          state_d;
   logic [0:WORD_W-1]   ic_q;
   logic [0:WORD_W-1]   ic_upd_d;
   logic                tmr_expired_s;
   logic                priv_trap_s;

   req_timer #(
      .LIMIT(TIMEOUT)
   ) u_req_timer (
      .clk_i     (clk),
      .reset_i   (reset),
      .clr_i     (state_q == IFS_IDLE),
      .en_i      (state_q == IFS_REQ),
      .expired_o (tmr_expired_s)
   );

   // State and instruction counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IFS_IDLE;
         ic_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         ic_q    <= ic_upd_d;
      end
   end

   // Next state; mem_ok beats both abort and the final timer cycle.
   always_comb begin
      state_d  = state_q;
      ic_upd_d = ic_q;
      case (state_q)
         IFS_IDLE: begin
            if (ic_load) begin
               ic_upd_d = ic_d;
            end else if (start) begin
               state_d = IFS_REQ;
            end else begin
               state_d = IFS_IDLE;
            end
         end
         IFS_REQ: begin
            if (mem_ok) begin
               ic_upd_d = ic_next(ic_q);
               state_d  = IFS_CHECK;
            end else if (abort) begin
               state_d = IFS_IDLE;
            end else if (tmr_expired_s) begin
               state_d = IFS_ALARM;
            end else begin
               state_d = IFS_REQ;
            end
         end
         IFS_CHECK: state_d = IFS_IDLE;
         IFS_ALARM: state_d = IFS_IDLE;
         default:   state_d = IFS_IDLE;
      endcase
   end

   assign priv_trap_s = user & ir_priv;

   // Outputs decoded from state; ir_c is suppressed while reset is pending.
   always_comb begin
      mem_req       = 1'b0;
      ir_c          = 1'b0;
      ir_invalidate = 1'b0;
      fetched       = 1'b0;
      illegal_irq   = 1'b0;
      no_answer_irq = 1'b0;
      busy          = 1'b1;
      case (state_q)
         IFS_IDLE: busy = 1'b0;
         IFS_REQ: begin
            mem_req = 1'b1;
            ir_c    = mem_ok & ~reset;
         end
         IFS_CHECK: begin
            if (priv_trap_s) begin
               ir_invalidate = 1'b1;
               illegal_irq   = 1'b1;
            end else begin
               fetched = 1'b1;
            end
         end
         IFS_ALARM: no_answer_irq = 1'b1;
         default:   busy = 1'b0;
      endcase
   end

   assign mem_addr = ic_q;
   assign ic       = ic_q;

endmodule

// File: tb/tb_ifetch_ctl.sv
// Self-checking bench for ifetch_ctl: scoreboard of expected completion pulses
// plus per-scenario inline checks, with a small behavioural IR.
module tb_ifetch_ctl;

   logic        clk;
   logic        reset;
   logic        start;
   logic        abort;
   logic        ic_load;
   logic [0:15] ic_d;
   logic        mem_ok;
   logic        user;
   logic        ir_priv;
   logic        mem_req;
   logic [0:15] mem_addr;
   logic        ir_c;
   logic        ir_invalidate;
   logic [0:15] ic;
   logic        busy;
   logic        fetched;
   logic        illegal_irq;
   logic        no_answer_irq;

   logic [0:15] mem_data;
   logic [0:15] ir;

   typedef struct packed {
      logic        f;
      logic        il;
      logic        inv;
      logic        na;
      logic [15:0] ic_v;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_exp;
   exp_t mon_got;
   int   vectors;
   int   miscompares;
   logic mon_en;

   ifetch_ctl #(.TIMEOUT(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .ic_load       (ic_load),
      .ic_d          (ic_d),
      .mem_ok        (mem_ok),
      .user          (user),
      .ir_priv       (ir_priv),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .ir_c          (ir_c),
      .ir_invalidate (ir_invalidate),
      .ic            (ic),
      .busy          (busy),
      .fetched       (fetched),
      .illegal_irq   (illegal_irq),
      .no_answer_irq (no_answer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural IR: privileged class when IR[0:1] == 2'b11.
   always @(posedge clk) begin
      if (ir_c === 1'b1) ir <= mem_data;
      else if (ir_invalidate === 1'b1) ir[0:1] <= 2'b00;
   end
   assign ir_priv = (ir[0:1] == 2'b11);

   // Scoreboard: every completion pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (mon_en && (fetched === 1'b1 || illegal_irq === 1'b1 ||
                     ir_invalidate === 1'b1 || no_answer_irq === 1'b1)) begin
         vectors++;
         mon_got = {fetched, illegal_irq, ir_invalidate, no_answer_irq, 16'(ic)};
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected got=%h required=none", mon_got);
         end else begin
            mon_exp = sb_q.pop_front();
            if (mon_got !== mon_exp) begin
               miscompares++;
               $display("FAIL sb_event got=%h required=%h", mon_got, mon_exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ic(input logic [0:15] v);
      ic_load = 1'b1;
      ic_d    = v;
      tick();
      ic_load = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({mem_req, ir_c, ir_invalidate, busy, fetched, illegal_irq, no_answer_irq} !== 7'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got=%b required=0000000",
                  {mem_req, ir_c, ir_invalidate, busy, fetched, illegal_irq, no_answer_irq});
      end
      vectors++;
      if (ic !== 16'h0000 || mem_addr !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_ic got=%h/%h required=0000/0000", ic, mem_addr);
      end
      tick();
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_load_fetch();
      load_ic(16'h0100);
      vectors++;
      if (ic !== 16'h0100) begin
         miscompares++;
         $display("FAIL load_ic got=%h required=0100", ic);
      end
      start = 1'b1;
      sb_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 16'h0101});
      tick();
      start    = 1'b0;
      mem_ok   = 1'b1;
      mem_data = 16'h1234;
      @(negedge clk);
      vectors++;
      if ({mem_req, ir_c, busy} !== 3'b111 || mem_addr !== 16'h0100) begin
         miscompares++;
         $display("FAIL fetch_req got=%b addr=%h required=111 addr=0100",
                  {mem_req, ir_c, busy}, mem_addr);
      end
      tick();
      mem_ok = 1'b0;
      @(negedge clk);
      vectors++;
      if ({mem_req, ir_c, busy} !== 3'b001 || ic !== 16'h0101 || ir !== 16'h1234) begin
         miscompares++;
         $display("FAIL fetch_check got=%b ic=%h ir=%h required=001 ic=0101 ir=1234",
                  {mem_req, ir_c, busy}, ic, ir);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || fetched !== 1'b0) begin
         miscompares++;
         $display("FAIL fetch_done got=%b%b required=00", busy, fetched);
      end
   endtask

   task automatic test_load_priority();
      ic_load = 1'b1;
      start   = 1'b1;
      ic_d    = 16'h0A0A;
      tick();
      ic_load = 1'b0;
      start   = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || ic !== 16'h0A0A) begin
         miscompares++;
         $display("FAIL load_priority got=%b ic=%h required=0 ic=0A0A", busy, ic);
      end
      tick();
   endtask

   task automatic test_wrap();
      load_ic(16'hFFFF);
      user  = 1'b1;
      start = 1'b1;
      sb_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      tick();
      start    = 1'b0;
      mem_ok   = 1'b1;
      mem_data = 16'h0ABC;
      @(negedge clk);
      vectors++;
      if (mem_addr !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL wrap_addr got=%h required=FFFF", mem_addr);
      end
      tick();
      mem_ok = 1'b0;
      @(negedge clk);
      vectors++;
      if (ic !== 16'h0000) begin
         miscompares++;
         $display("FAIL wrap_ic got=%h required=0000", ic);
      end
      tick();
      user = 1'b0;
   endtask

   task automatic test_illegal(input logic usr, input logic [0:15] word);
      load_ic(16'h0200);
      user  = usr;
      start = 1'b1;
      sb_q.push_back({~usr, usr, usr, 1'b0, 16'h0201});
      tick();
      start    = 1'b0;
      mem_ok   = 1'b1;
      mem_data = word;
      tick();
      mem_ok = 1'b0;
      tick();
      vectors++;
      if (ir[0:1] !== (usr ? 2'b00 : word[0:1]) || ir[2:15] !== word[2:15]) begin
         miscompares++;
         $display("FAIL illegal_ir got=%h user=%b word=%h", ir, usr, word);
      end
      user = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n_f;
      n_f = 0;
      load_ic(16'h0500);
      for (int k = 1; k <= 3; k++) sb_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0500 + k)});
      start    = 1'b1;
      mem_ok   = 1'b1;
      mem_data = 16'h0001;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (fetched === 1'b1) n_f++;
      end
      start  = 1'b0;
      mem_ok = 1'b0;
      tick();
      vectors++;
      if (n_f !== 3 || ic !== 16'h0503 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL back_to_back got=%0d ic=%h busy=%b required=3 ic=0503 busy=0", n_f, ic, busy);
      end
   endtask

   task automatic test_timeout();
      int n_req;
      int n_irc;
      n_req = 0;
      n_irc = 0;
      load_ic(16'h0300);
      start = 1'b1;
      sb_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 16'h0300});
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req === 1'b1) n_req++;
         if (ir_c === 1'b1) n_irc++;
      end
      tick();
      vectors++;
      if (n_req !== 16 || n_irc !== 0 || ic !== 16'h0300 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout got=%0d/%0d ic=%h busy=%b required=16/0 ic=0300 busy=0",
                  n_req, n_irc, ic, busy);
      end
   endtask

   task automatic test_timeout_edge();
      load_ic(16'h0600);
      start = 1'b1;
      sb_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 16'h0601});
      tick();
      start = 1'b0;
      repeat (15) tick();
      mem_ok   = 1'b1;
      mem_data = 16'h0011;
      @(negedge clk);
      vectors++;
      if ({mem_req, ir_c} !== 2'b11) begin
         miscompares++;
         $display("FAIL timeout_edge_req got=%b required=11", {mem_req, ir_c});
      end
      tick();
      mem_ok = 1'b0;
      @(negedge clk);
      vectors++;
      if (no_answer_irq !== 1'b0 || ic !== 16'h0601) begin
         miscompares++;
         $display("FAIL timeout_edge got=%b ic=%h required=0 ic=0601", no_answer_irq, ic);
      end
      tick();
      tick();
   endtask

   task automatic test_abort();
      load_ic(16'h0700);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, mem_req} !== 2'b00 || ic !== 16'h0700) begin
         miscompares++;
         $display("FAIL abort got=%b ic=%h required=00 ic=0700", {busy, mem_req}, ic);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      load_ic(16'h0400);
      start = 1'b1;
      tick();
      start    = 1'b0;
      reset    = 1'b1;
      mem_ok   = 1'b1;
      mem_data = 16'hFFFF;
      @(negedge clk);
      vectors++;
      if (ir_c !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_irc got=%b required=0", ir_c);
      end
      tick();
      reset  = 1'b0;
      mem_ok = 1'b0;
      @(negedge clk);
      vectors++;
      if ({mem_req, busy} !== 2'b00 || ic !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_mid got=%b ic=%h required=00 ic=0000", {mem_req, busy}, ic);
      end
      tick();
      tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      mon_en      = 1'b0;
      reset       = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      ic_load     = 1'b0;
      ic_d        = 16'h0000;
      mem_ok      = 1'b0;
      user        = 1'b0;
      mem_data    = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_load_fetch();
      test_load_priority();
      test_wrap();
      test_illegal(1'b1, 16'hC123);
      test_illegal(1'b0, 16'hC456);
      test_back_to_back();
      test_timeout();
      test_timeout_edge();
      test_abort();
      test_reset_mid();
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover got=%0d required=0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
